// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - mem/debug two-port data-memory controller with byte-lane read-modify-write
// Optional macro DMEM_PORT_CTRL_DBG_EN enables arbitration of the debug port.
module dmem_port_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_be,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ack,
  output logic [31:0]           mem_rdata,
  output logic                  mem_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [3:0]            dbg_be,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [31:0]           dbg_rdata,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_read,
  output logic                  dm_write,
  output logic [31:0]           dm_wdata,
  input  logic [31:0]           dm_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RD_DATA, RMW_RD, RMW_MERGE, WR, ACK} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-3:0] waddr_q, waddr_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           data_q, data_d;
  logic                  gnt_dbg_q, gnt_dbg_d;
  logic                  last_dbg_q, last_dbg_d;

  logic                  pick_dbg;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [3:0]            sel_be;
  logic [31:0]           sel_wdata;

`ifdef DMEM_PORT_CTRL_DBG_EN
  logic unused_lsb;
  // Round-robin: on a tie the port that did not win last time is granted.
  assign pick_dbg  = dbg_req & (~mem_req | ~last_dbg_q);
  assign sel_we    = pick_dbg ? dbg_we    : mem_we;
  assign sel_addr  = pick_dbg ? dbg_addr  : mem_addr;
  assign sel_be    = pick_dbg ? dbg_be    : mem_be;
  assign sel_wdata = pick_dbg ? dbg_wdata : mem_wdata;
  assign unused_lsb = ^{mem_addr[1:0], dbg_addr[1:0]};
`else
  logic unused_dbg;
  assign pick_dbg  = 1'b0;
  assign sel_we    = mem_we;
  assign sel_addr  = mem_addr;
  assign sel_be    = mem_be;
  assign sel_wdata = mem_wdata;
  assign unused_dbg = ^{dbg_req, dbg_we, dbg_addr, dbg_be, dbg_wdata, mem_addr[1:0]};
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      be_q       <= 4'h0;
      data_q     <= 32'h0;
      gnt_dbg_q  <= 1'b0;
      last_dbg_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      be_q       <= be_d;
      data_q     <= data_d;
      gnt_dbg_q  <= gnt_dbg_d;
      last_dbg_q <= last_dbg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    be_d       = be_q;
    data_d     = data_q;
    gnt_dbg_d  = gnt_dbg_q;
    last_dbg_d = last_dbg_q;
    case (state_q)
      IDLE: begin
        if (mem_req || pick_dbg) begin
          gnt_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          we_d       = sel_we;
          waddr_d    = sel_addr[ADDR_WIDTH-1:2];
          be_d       = sel_be;
          data_d     = sel_wdata;
          if (!sel_we)               state_d = RD;
          else if (sel_be == 4'hF)   state_d = WR;
          else if (sel_be == 4'h0)   state_d = ACK;
          else                       state_d = RMW_RD;
        end
      end
      RD:      state_d = RD_DATA;
      RD_DATA: begin
        data_d  = dm_rdata;
        state_d = ACK;
      end
      RMW_RD:  state_d = RMW_MERGE;
      // data_q still holds the store data here; overlay it on the fetched word.
      RMW_MERGE: begin
        for (int i = 0; i < 4; i++) begin
          data_d[8*i +: 8] = be_q[i] ? data_q[8*i +: 8] : dm_rdata[8*i +: 8];
        end
        state_d = WR;
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dm_read   = (state_q == RD) || (state_q == RMW_RD);
  assign dm_write  = (state_q == WR);
  assign dm_addr   = (state_q == IDLE) ? '0 : {waddr_q, 2'b00};
  assign dm_wdata  = dm_write ? data_q : 32'h0;

  assign mem_ack   = (state_q == ACK) & ~gnt_dbg_q;
  assign mem_rdata = (mem_ack & ~we_q) ? data_q : 32'h0;
  assign mem_stall = mem_req & ~mem_ack;

`ifdef DMEM_PORT_CTRL_DBG_EN
  assign dbg_ack   = (state_q == ACK) & gnt_dbg_q;
  assign dbg_rdata = (dbg_ack & ~we_q) ? data_q : 32'h0;
`else
  assign dbg_ack   = 1'b0;
  assign dbg_rdata = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - self-checking bench for dmem_port_ctrl against a transaction-level model
module tb_dmem_port_ctrl;
  localparam int AW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          mem_req, mem_we, mem_ack, mem_stall;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [3:0]    dbg_be;
  logic [31:0]   dbg_wdata, dbg_rdata;
  logic [AW-1:0] dm_addr;
  logic          dm_read, dm_write;
  logic [31:0]   dm_wdata, dm_rdata;

  dmem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RESET(RESET),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dm_addr(dm_addr), .dm_read(dm_read), .dm_write(dm_write),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [31:0] dm_mem [0:255];
  logic [31:0] gold   [0:255];

  // Transaction model: one outstanding grant, position counted in cycles since the request was taken.
  bit          m_busy, m_dbg, m_we, m_last_dbg;
  int          m_off, m_lat;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_be;
  bit          ack_seen [2];
  bit          drv_random;
  bit          rd_pend;
  logic [7:0]  rd_idx;

  bit          obs_mack, obs_dack, obs_rd, obs_wr, obs_stall;
  logic [31:0] obs_wdata, obs_mrdata, obs_drdata, obs_rdaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input bit we, input logic [3:0] be);
    if (!we) return 3;
    if (be == 4'hF) return 2;
    if (be == 4'h0) return 1;
    return 4;
  endfunction

  function automatic logic [31:0] merge(input logic [3:0] be, input logic [31:0] wd, input logic [31:0] old);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_off = 0; m_last_dbg = 1; rd_pend = 0;
  endtask

  task automatic check_phase();
    bit e_ack, e_rd, e_wr;
    logic [31:0] e_addr, e_rdata;
    e_ack   = m_busy && (m_off == m_lat);
    e_rd    = m_busy && (m_off == 1) && (!m_we || m_lat == 4);
    e_wr    = m_busy && ((m_lat == 2 && m_off == 1) || (m_lat == 4 && m_off == 3));
    e_addr  = m_busy ? (m_addr & 32'hFFFF_FFFC) : 32'h0;
    e_rdata = (e_ack && !m_we) ? gold[m_addr[9:2]] : 32'h0;
    chk("dm_read",   32'(dm_read),   32'(e_rd));
    chk("dm_write",  32'(dm_write),  32'(e_wr));
    chk("dm_addr",   dm_addr,        e_addr);
    chk("mem_ack",   32'(mem_ack),   32'(e_ack && !m_dbg));
    chk("dbg_ack",   32'(dbg_ack),   32'(e_ack && m_dbg));
    chk("mem_rdata", mem_rdata,      m_dbg ? 32'h0 : e_rdata);
    chk("dbg_rdata", dbg_rdata,      m_dbg ? e_rdata : 32'h0);
    chk("mem_stall", 32'(mem_stall), 32'(mem_req && !(e_ack && !m_dbg)));
    if (e_wr) chk("dm_wdata", dm_wdata, merge(m_be, m_wd, gold[m_addr[9:2]]));
    obs_mack = mem_ack; obs_dack = dbg_ack; obs_rd = dm_read; obs_wr = dm_write;
    obs_stall = mem_stall; obs_wdata = dm_wdata; obs_mrdata = mem_rdata;
    obs_drdata = dbg_rdata; obs_rdaddr = dm_addr;
    if (dm_write) dm_mem[dm_addr[9:2]] = dm_wdata;
    rd_pend = dm_read;
    rd_idx  = dm_addr[9:2];
    ack_seen[0] = e_ack && !m_dbg;
    ack_seen[1] = e_ack && m_dbg;
    if (e_ack && m_we) gold[m_addr[9:2]] = merge(m_be, m_wd, gold[m_addr[9:2]]);
  endtask

  task automatic advance();
    bit dr;
    if (!RESET) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (m_off == m_lat) begin m_busy = 0; m_off = 0; end
      else m_off++;
    end else begin
`ifdef DMEM_PORT_CTRL_DBG_EN
      dr = dbg_req;
`else
      dr = 1'b0;
`endif
      if (mem_req || dr) begin
        m_dbg      = dr && (!mem_req || !m_last_dbg);
        m_last_dbg = m_dbg;
        m_we   = m_dbg ? dbg_we    : mem_we;
        m_addr = m_dbg ? dbg_addr  : mem_addr;
        m_be   = m_dbg ? dbg_be    : mem_be;
        m_wd   = m_dbg ? dbg_wdata : mem_wdata;
        m_lat  = lat_of(m_we, m_be);
        m_busy = 1;
        m_off  = 1;
      end
    end
  endtask

  task automatic set_port(input bit p, input bit req, input bit we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
    if (!p) begin mem_req = req; mem_we = we; mem_addr = addr; mem_be = be; mem_wdata = wd; end
    else    begin dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_be = be; dbg_wdata = wd; end
  endtask

  task automatic rand_port(input bit p, input bit req);
    int s;
    logic [3:0] be;
    s  = $urandom_range(0, 3);
    be = (s == 0) ? 4'hF : (s == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    set_port(p, req, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)), be, $urandom());
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      bit pp;
      bit req_now;
      pp = 1'(p);
      req_now = pp ? dbg_req : mem_req;
      if (ack_seen[p] || !req_now) rand_port(pp, $urandom_range(0, 2) != 0);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_phase();
    @(posedge CLK);
    advance();
    #1;
    dm_rdata = rd_pend ? dm_mem[rd_idx] : $urandom();
    if (drv_random) drive_random();
  endtask

  task automatic directed(input bit p, input bit we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output int lat, output int nrd, output int nwr,
                          output logic [31:0] wv, output logic [31:0] rv, output logic [31:0] rda,
                          output int stall_cyc);
    lat = -1; nrd = 0; nwr = 0; wv = 0; rv = 0; rda = 0; stall_cyc = 0;
    set_port(p, 1'b1, we, addr, be, wd);
    for (int i = 0; i < 12 && lat < 0; i++) begin
      cycle();
      nrd += int'(obs_rd);
      nwr += int'(obs_wr);
      if (obs_rd) rda = obs_rdaddr;
      if (obs_wr) wv = obs_wdata;
      if (obs_stall) stall_cyc++;
      if (p ? obs_dack : obs_mack) begin
        lat = i;
        rv  = p ? obs_drdata : obs_mrdata;
      end
    end
    set_port(p, 1'b0, we, addr, be, wd);
  endtask

  initial begin
    int lat, nrd, nwr, sc, nack, n, ndack, rst_hold;
    logic [31:0] wv, rv, rda;
    logic [3:0] ord;

    RESET = 1'b0;
    drv_random = 0;
    model_reset();
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    dm_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      dm_mem[i] = $urandom();
      gold[i]   = dm_mem[i];
    end
    cycle();
    cycle();
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_strobes", 32'({dm_read, dm_write}), 32'h0);
    chk("rst_acks",    32'({mem_ack, dbg_ack}), 32'h0);
    chk("rst_rdata",   mem_rdata | dbg_rdata | dm_wdata, 32'h0);
    RESET = 1'b1;
    cycle();

    // Load from 0x106, DM word at 0x104
    dm_mem[65] = 32'h1122_3344; gold[65] = 32'h1122_3344;
    directed(0, 0, 32'h106, 4'h0, 32'h0, lat, nrd, nwr, wv, rv, rda, sc);
    chk("load_lat",   32'(lat), 32'd3);
    chk("load_nrd",   32'(nrd), 32'd1);
    chk("load_nwr",   32'(nwr), 32'd0);
    chk("load_addr",  rda, 32'h104);
    chk("load_rdata", rv, 32'h1122_3344);
    chk("load_stall", 32'(sc), 32'd3);

    // Partial store
    dm_mem[128] = 32'hFFFF_FFFF; gold[128] = 32'hFFFF_FFFF;
    directed(0, 1, 32'h200, 4'b0100, 32'h00AB_0000, lat, nrd, nwr, wv, rv, rda, sc);
    chk("pst_lat",   32'(lat), 32'd4);
    chk("pst_nrd",   32'(nrd), 32'd1);
    chk("pst_nwr",   32'(nwr), 32'd1);
    chk("pst_wdata", wv, 32'hFFAB_FFFF);
    chk("pst_rdata", rv, 32'h0);
    chk("pst_dm",    dm_mem[128], 32'hFFAB_FFFF);

    // Full store and empty store
    directed(0, 1, 32'h300, 4'hF, 32'hDEAD_BEEF, lat, nrd, nwr, wv, rv, rda, sc);
    chk("fst_lat",   32'(lat), 32'd2);
    chk("fst_nrd",   32'(nrd), 32'd0);
    chk("fst_nwr",   32'(nwr), 32'd1);
    chk("fst_wdata", wv, 32'hDEAD_BEEF);
    directed(0, 1, 32'h304, 4'h0, 32'h1234_5678, lat, nrd, nwr, wv, rv, rda, sc);
    chk("est_lat",   32'(lat), 32'd1);
    chk("est_dm",    32'(nrd + nwr), 32'd0);

`ifdef DMEM_PORT_CTRL_DBG_EN
    directed(1, 0, 32'h300, 4'h0, 32'h0, lat, nrd, nwr, wv, rv, rda, sc);
    chk("dbg_load_lat",   32'(lat), 32'd3);
    chk("dbg_load_rdata", rv, 32'hDEAD_BEEF);
`endif

    // Reset while the partial store sits in its merge cycle
    dm_mem[130] = 32'h1234_5678; gold[130] = 32'h1234_5678;
    set_port(0, 1, 1, 32'h208, 4'b0011, 32'hCAFE_F00D);
    cycle();
    cycle();
    RESET = 1'b0;
    model_reset();
    nwr = 0; nack = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      nwr  += int'(obs_wr);
      nack += int'(obs_mack | obs_dack);
    end
    chk("rst_mid_nwr", 32'(nwr), 32'd0);
    chk("rst_mid_ack", 32'(nack), 32'd0);
    RESET = 1'b1;
    directed(0, 1, 32'h208, 4'b0011, 32'hCAFE_F00D, lat, nrd, nwr, wv, rv, rda, sc);
    chk("rst_redo_lat",   32'(lat), 32'd4);
    chk("rst_redo_wdata", wv, 32'h1234_F00D);

    // Contention straight out of reset
    RESET = 1'b0;
    model_reset();
    cycle();
    set_port(0, 1, 0, 32'h010, 4'h0, 32'h0);
    set_port(1, 1, 0, 32'h020, 4'h0, 32'h0);
    RESET = 1'b1;
    n = 0; ndack = 0; ord = 4'h0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      cycle();
      if (obs_mack || obs_dack) begin
        ord = {ord[2:0], obs_dack};
        n++;
      end
      ndack += int'(obs_dack);
    end
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    chk("contend_n", 32'(n), 32'd4);
`ifdef DMEM_PORT_CTRL_DBG_EN
    chk("contend_order", 32'(ord), 32'b0101);
`else
    chk("contend_order", 32'(ord), 32'b0000);
    chk("contend_dbg_ack", 32'(ndack), 32'd0);
`endif
    cycle();

    // Randomised traffic with occasional asynchronous resets
    drv_random = 1;
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (RESET && $urandom_range(0, 199) == 0) begin
        RESET = 1'b0;
        model_reset();
        rst_hold = $urandom_range(1, 3);
      end else if (!RESET) begin
        rst_hold--;
        if (rst_hold <= 0) RESET = 1'b1;
      end
      cycle();
    end
    drv_random = 0;
    RESET = 1'b1;
    set_port(0, 0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
